// File: rtl/pam_demod_param_pkg.sv
// Shared types and helpers for the parametrised M-ary PAM demodulator.
// Thresholds and widths are derived here so the top level and the averager agree.
package pam_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Default level count; parametrised instances use levels(SYM_BITS).
  localparam int M = 4;

  function automatic int levels(int sym_bits);
    return 1 << sym_bits;
  endfunction

  function automatic int thr(int k, int offset, int step);
    return offset + k * step;
  endfunction

  function automatic int sum_w(int in_w, int avg_log2);
    return in_w + avg_log2;
  endfunction

endpackage

// File: rtl/pam_demod_param_if.sv
// Sample-in / symbol-out bundle for pam_demod_param.
interface pam_demod_param_if #(
  parameter int IN_W     = 8,
  parameter int SYM_BITS = 2
);
  logic                   in_valid;
  logic signed [IN_W-1:0] in_sample;
  logic                   sym_sync;
  logic [SYM_BITS-1:0]    sym_out;
  logic                   sym_valid;
  logic [IN_W-1:0]        avg_out;

  modport master (
    output in_valid, in_sample, sym_sync,
    input  sym_out, sym_valid, avg_out
  );

  modport slave (
    input  in_valid, in_sample, sym_sync,
    output sym_out, sym_valid, avg_out
  );
endinterface

// File: rtl/pam_demod_param_moving_avg.sv
// Power-of-two moving average over rectified magnitudes, with a fill flag
// that rises once the window holds N real samples.
module pam_moving_avg
  import pam_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int AVG_LOG2 = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [IN_W-1:0] mag,
  output logic [IN_W-1:0] avg,
  output logic            filled
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = sum_w(IN_W, AVG_LOG2);
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW = AVG_LOG2 + 1;

  logic [IN_W-1:0] win [N];
  logic [PW-1:0]   wr_ptr;
  logic [SW-1:0]   sum;
  logic [FW-1:0]   fill;

  // The slot being overwritten is the oldest sample, so it leaves the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      fill   <= '0;
    end else if (en) begin
      win[wr_ptr] <= mag;
      sum         <= sum + SW'(mag) - SW'(win[wr_ptr]);
      wr_ptr      <= (int'(wr_ptr) == N - 1) ? '0 : wr_ptr + 1'b1;
      if (!filled) fill <= fill + 1'b1;
    end
  end

  assign filled = (fill == FW'(N));
  assign avg    = IN_W'(sum >> AVG_LOG2);

endmodule

// File: rtl/pam_demod_param.sv
// M-ary PAM demodulator: rectify, moving-average, slice, one symbol per SPS
// accepted samples, with resync on sym_sync and warm-up strobe suppression.
module pam_demod_param
  import pam_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int SYM_BITS = 2,
  parameter int AVG_LOG2 = 3,
  parameter int SPS      = 16,
  parameter int OFFSET   = 9,
  parameter int STEP     = 19
) (
  input logic               clk,
  input logic               rst,
  pam_demod_param_if.slave  bus
);

  localparam int LVLS  = levels(SYM_BITS);
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  if (SPS < (1 << AVG_LOG2)) begin : g_chk_sps
    $error("SPS must be at least the moving-average window length");
  end
  if (thr(LVLS - 2, OFFSET, STEP) >= (1 << (IN_W - 1))) begin : g_chk_thr
    $error("Top decision threshold exceeds the magnitude range");
  end

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_now;
  logic [IN_W-1:0]     mag_now, mag_q, avg, avg_q;
  logic                mag_v, filled;
  logic                dec1, dec2, dec3;
  logic [SYM_BITS-1:0] level, sym_q;
  logic                sym_v_q;

  // Full-width negate so the most negative sample maps to 2**(IN_W-1).
  assign mag_now = bus.in_sample[IN_W-1] ? (~bus.in_sample + 1'b1) : bus.in_sample;
  assign cnt_now = bus.sym_sync ? '0 : cnt;

  pam_moving_avg #(.IN_W(IN_W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk    (clk),
    .rst    (rst),
    .en     (mag_v),
    .mag    (mag_q),
    .avg    (avg),
    .filled (filled)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WARMUP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WARMUP:  if (filled) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = WARMUP;
    endcase
  end

  always_comb begin
    level = '0;
    for (int k = 0; k < LVLS - 1; k++)
      if (int'(avg_q) > thr(k, OFFSET, STEP)) level = level + 1'b1;
  end

  // Decision flags ride alongside the data and drain even through in_valid gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mag_q   <= '0;
      mag_v   <= 1'b0;
      dec1    <= 1'b0;
      dec2    <= 1'b0;
      dec3    <= 1'b0;
      avg_q   <= '0;
      sym_q   <= '0;
      sym_v_q <= 1'b0;
    end else begin
      mag_v <= bus.in_valid;
      dec1  <= bus.in_valid && (cnt_now == LAST) && (state == RUN);
      if (bus.in_valid) begin
        mag_q <= mag_now;
        cnt   <= (cnt_now == LAST) ? '0 : cnt_now + 1'b1;
      end
      dec2    <= dec1;
      avg_q   <= avg;
      dec3    <= dec2;
      sym_v_q <= dec3;
      if (dec3) sym_q <= level;
    end
  end

  assign bus.avg_out   = avg_q;
  assign bus.sym_out   = sym_q;
  assign bus.sym_valid = sym_v_q;

endmodule

// File: tb/tb_pam_demod_param.sv
// Self-checking bench for pam_demod_param: directed and random streams checked
// against a window-average / threshold-count reference model.
module tb_pam_demod_param;

  localparam int IN_W     = 8;
  localparam int SYM_BITS = 2;
  localparam int AVG_LOG2 = 3;
  localparam int SPS      = 16;
  localparam int OFFSET   = 9;
  localparam int STEP     = 19;
  localparam int N        = 1 << AVG_LOG2;
  localparam int LVLS     = 1 << SYM_BITS;

  typedef struct {
    int due;
    int sym;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;

  exp_t expq[$];
  int   hist[$];
  int   cnt_m = 0;
  int   accepted = 0;

  int bvals[6] = '{9, 10, 28, 29, 47, 48};
  int bsyms[6] = '{0, 1, 1, 2, 2, 3};

  pam_demod_param_if #(.IN_W(IN_W), .SYM_BITS(SYM_BITS)) bus ();

  pam_demod_param #(
    .IN_W(IN_W), .SYM_BITS(SYM_BITS), .AVG_LOG2(AVG_LOG2),
    .SPS(SPS), .OFFSET(OFFSET), .STEP(STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / N;
  endfunction

  function automatic int ref_level(int a);
    int n = 0;
    for (int k = 0; k <= LVLS - 2; k++)
      if (a > OFFSET + k * STEP) n++;
    return n;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // One clock step: check outputs due now, then drive inputs and update the model.
  task automatic applyStimulus(bit r, bit v, int s, bit sy);
    bit exp_v;
    int c, mag;
    @(negedge clk);
    if (checking) begin
      exp_v = (expq.size() > 0) && (expq[0].due == cyc);
      checkOutput("sym_valid", bus.sym_valid, exp_v);
      if (exp_v) begin
        checkOutput("sym_out", bus.sym_out, expq[0].sym);
        void'(expq.pop_front());
      end
    end
    rst           = r;
    bus.in_valid  = v;
    bus.in_sample = IN_W'(s);
    bus.sym_sync  = sy;
    if (r) begin
      expq.delete();
      hist.delete();
      cnt_m    = 0;
      accepted = 0;
    end else if (v) begin
      c     = sy ? 0 : cnt_m;
      cnt_m = (c == SPS - 1) ? 0 : c + 1;
      mag   = (s < 0) ? -s : s;
      hist.push_back(mag);
      if (hist.size() > N) void'(hist.pop_front());
      accepted++;
      if (c == SPS - 1 && accepted > N)
        expq.push_back('{due: cyc + 4, sym: ref_level(ref_avg())});
    end
  endtask

  task automatic feed(int value, int count, bit sync_first);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b1, value, sync_first && i == 0);
  endtask

  task automatic idle(int count);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 50, 1'b0);
    applyStimulus(1'b1, 1'b1, 50, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("rst_sym_valid", bus.sym_valid, 0);
    checkOutput("rst_sym_out", bus.sym_out, 0);
    checkOutput("rst_avg_out", bus.avg_out, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.sym_sync  = 1'b0;
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checking = 1'b1;
    doReset();

    feed(40, 48, 1'b1);
    idle(4);
    checkOutput("avg_const40", bus.avg_out, 40);
    checkOutput("sym_const40", bus.sym_out, 2);

    for (int i = 0; i < 6; i++) begin
      feed(bvals[i], 32, 1'b1);
      idle(4);
      checkOutput("slice_boundary", bus.sym_out, bsyms[i]);
    end

    feed(-128, 32, 1'b1);
    idle(4);
    checkOutput("avg_neg128", bus.avg_out, 128);
    checkOutput("sym_neg128", bus.sym_out, 3);
    feed(-5, 32, 1'b1);
    idle(4);
    checkOutput("sym_neg5", bus.sym_out, 0);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b1, (i % 2 == 1) ? -30 : 30, i == 0);
    idle(4);
    checkOutput("avg_alt30", bus.avg_out, 30);
    checkOutput("sym_alt30", bus.sym_out, 2);

    feed(60, 7, 1'b1);
    feed(35, 16, 1'b1);
    idle(4);
    checkOutput("sym_resync", bus.sym_out, 2);

    for (int i = 0; i < 64; i++) applyStimulus(1'b0, i % 2 == 0, 20, i == 0);
    idle(4);
    checkOutput("sym_gapped", bus.sym_out, 1);
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, $urandom_range(0, 2) != 0, 20, 1'b0);
    idle(4);
    checkOutput("sym_rand_gaps", bus.sym_out, 1);

    for (int i = 0; i < 600; i++)
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                    $urandom_range(0, 40) == 0);

    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                    $urandom_range(0, 60) == 0);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pam_demod_param.md
Name: pam_demod_param

Overview:
Parametrised M-ary PAM demodulator. It is the successor to the fixed 8-bit/4-level demodulator.
- Datapath: rectifies signed baseband samples, smooths them with a power-of-two moving-average window, slices the average against evenly spaced thresholds, and emits one symbol per SPS accepted samples.
- Adds over the previous generation: valid qualification, symbol-boundary resync, warm-up suppression, correct two's-complement rectification and reset.

Parameters:
IN_W, 8, signed input sample width
SYM_BITS, 2, bits per symbol; M = 2**SYM_BITS levels
AVG_LOG2, 3, log2 of moving-average window length N (N=8)
SPS, 16, accepted samples per symbol; must be >= N
OFFSET, 9, first decision threshold (magnitude units)
STEP, 19, spacing between successive thresholds

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_sample is accepted on this edge
in_sample  input  IN_W  signed baseband sample
sym_sync  input  1  qualified by in_valid: this sample is sample 0 of a symbol
sym_out  output  SYM_BITS  decided symbol
sym_valid  output  1  one-cycle strobe, sym_out is new
avg_out  output  IN_W  current moving-average magnitude (debug)

Behaviour:
- Reset (rst high at a clk edge) forces the following, and takes priority over all other inputs:
  - sym_out=0, sym_valid=0, avg_out=0.
  - Window buffer, running sum, sample counter and fill counter all cleared.
  - FSM set to WARMUP.
- Stage 1 (registered on in_valid): mag = |in_sample|, unsigned IN_W bits.
  - -2**(IN_W-1) maps to 2**(IN_W-1); no wrap. Example: -128 -> 128.
- Stage 2 (moving-average update):
  - Circular buffer of N mags, write pointer wraps N-1 -> 0.
  - Running sum is IN_W+AVG_LOG2 bits: sum <= sum + mag - oldest. It cannot overflow.
  - avg = sum >> AVG_LOG2 (truncating); avg_out updates here.
- Stage 3 (slicer):
  - Thresholds T_k = OFFSET + k*STEP for k = 0..M-2.
  - Decision = count of thresholds with avg > T_k.
  - Defaults: avg<=9 -> 0, <=28 -> 1, <=47 -> 2, else 3.
- Latency: sym_valid rises 3 clk after the edge that accepts the symbol's last sample, and is high for exactly 1 cycle.
- Symbol counter (0..SPS-1):
  - Advances only on accepted samples; wraps SPS-1 -> 0.
  - Decision is taken on the sample with count == SPS-1.
  - in_valid & sym_sync loads count=0 for that sample, overriding the wrap/increment. The partial symbol is discarded with no strobe.
  - sym_sync without in_valid is ignored.
- FSM:
  - WARMUP: fill counter increments per accepted sample. Enters RUN on the N-th accepted sample. Any decision point reached in WARMUP produces no sym_valid.
  - RUN: decisions are strobed. Stays in RUN until rst.
- in_valid gaps: the pipeline holds and the counters do not advance. Stage registers still drain, so a decision already in flight completes on schedule.
- Elaboration-time checks (fail if violated):
  - SPS >= 2**AVG_LOG2.
  - OFFSET + (M-2)*STEP < 2**(IN_W-1).

Decomposition:
- Package pam_pkg holds:
  - Level-count constant M.
  - Threshold function thr(k) = OFFSET + k*STEP.
  - FSM state enum {WARMUP, RUN}.
  - Sum-width helper (IN_W+AVG_LOG2).
- Sub-module pam_moving_avg:
  - Ports: clk, rst, en, mag in, avg out, filled flag.
  - Parametrised by IN_W and AVG_LOG2.
  - Contains the circular buffer, running sum and fill counter.
- Top level holds the rectifier, symbol counter, FSM and slicer.

Test Plan:
1. Reset: rst high 2 cycles mid-stream -> next cycle sym_valid=0, sym_out=0, avg_out=0; the first subsequent sym_valid occurs no earlier than 8 accepted samples after rst falls.
2. Constant +40, in_valid=1 continuous, sym_sync on sample 0 -> avg_out=40 after 8 samples; sym_valid pulses every 16 cycles, first at 3 cycles after sample 15; sym_out=2.
3. Slicer boundaries: constant inputs 9, 10, 28, 29, 47, 48 -> sym_out 0, 1, 1, 2, 2, 3 respectively.
4. Rectification: constant -128 -> avg_out=128, sym_out=3; constant -5 -> sym_out=0; alternating +30/-30 -> sym_out=2.
5. Resync: sym_sync with in_valid at count 7 -> no strobe for the aborted symbol; the next sym_valid follows the 16th accepted sample counted from the resync sample.
6. Gapped input: in_valid high every other cycle with constant +20 -> sym_out=1, sym_valid spacing 32 cycles; the pattern is unchanged by random gaps.
